// File: rtl/ula_pkg.sv
// ula_pkg -- shared types and constants for the ULA sequencer.
//   state_t   : sequencer stages, encoded as they appear on Stage
//   op_t      : ALU op codes as entered on Sw[2:0]
//   alu_out_t : one ALU evaluation (value plus flags)
//   in_display_range() : true when a byte, read as signed, fits the
//                        2-digit 7-segment display (-9..89)
package ula_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       overflow;
    } alu_out_t;

    localparam logic signed [7:0] DISP_MIN = -8'sd9;
    localparam logic signed [7:0] DISP_MAX = 8'sd89;

    function automatic logic in_display_range(input logic [7:0] v);
        return ($signed(v) >= DISP_MIN) && ($signed(v) <= DISP_MAX);
    endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// ula_sequencer_if -- user-facing bus of the ULA sequencer.
//   Sw       8  operand/opcode switches (to sequencer)
//   Key      1  raw push button, asynchronous (to sequencer)
//   Result   8  registered display value (from sequencer)
//   Stage    3  current stage encoding (from sequencer)
//   Carry    1  registered ALU carry/borrow flag (from sequencer)
//   Overflow 1  registered signed-overflow flag (from sequencer)
//   InRange  1  Result fits the display (from sequencer)
//   Done     1  one-cycle pulse on a new result (from sequencer)
// master = the side that owns the switches/button, slave = the sequencer.
interface ula_sequencer_if;

    logic [7:0] Sw;
    logic       Key;
    logic [7:0] Result;
    logic [2:0] Stage;
    logic       Carry;
    logic       Overflow;
    logic       InRange;
    logic       Done;

    modport master (
        output Sw, Key,
        input  Result, Stage, Carry, Overflow, InRange, Done
    );

    modport slave (
        input  Sw, Key,
        output Result, Stage, Carry, Overflow, InRange, Done
    );

endinterface

// File: rtl/key_edge.sv
// key_edge -- brings the raw button into the clock domain and turns each
// press into a single-cycle strobe.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   Key   in   raw active-high button, asynchronous to clk
//   press out  high for one cycle per rising edge of Key
// Key enters k1, k2 is the first safe sample and k3 remembers the previous
// one, so press is high after the second edge and is consumed by the
// sequencer at the third edge after Key rises. A held key gives one press.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic Key,
    output logic press
);

    logic k1_q, k2_q, k3_q;

    // NOTE: sequential state is always updated with <=, so every flop in the
    // chain samples the value from before the edge and the chain really is
    // three stages long; blocking = here would collapse it into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            k1_q <= 1'b0;
            k2_q <= 1'b0;
            k3_q <= 1'b0;
        end else begin
            k1_q <= Key;
            k2_q <= k1_q;
            k3_q <= k2_q;
        end
    end

    assign press = k2_q & ~k3_q;

endmodule

// File: rtl/ula_sequencer.sv
// ula_sequencer -- button-driven 8-bit ALU front end.
//   clk  in   rising-edge clock for all state
//   rst  in   synchronous active-high reset
//   bus  slave modport of ula_sequencer_if (Sw/Key in; Result, Stage,
//        Carry, Overflow, InRange, Done out)
// The user enters A, B and an op code with one button press each; the
// result is computed in a single S_EXEC cycle and held in S_SHOW until the
// next press returns to S_A. While entering, Result echoes the switches.
module ula_sequencer
    import ula_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ula_sequencer_if.slave bus
);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    op_t        op_q, op_d;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;
    logic       done_q, done_d;
    logic       press;
    alu_out_t   alu;

    key_edge u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .Key   (bus.Key),
        .press (press)
    );

    // 8-bit two's-complement ALU; all results wrap modulo 256.
    function automatic alu_out_t alu_eval(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input op_t        op);
        alu_out_t   o;
        logic [8:0] wide;
        o    = '0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide       = {1'b0, a} + {1'b0, b};
                o.result   = wide[7:0];
                o.carry    = wide[8];
                o.overflow = (a[7] == b[7]) && (o.result[7] != a[7]);
            end
            OP_SUB: begin
                // bit 8 of the 9-bit difference is the borrow (A < B unsigned)
                wide       = {1'b0, a} - {1'b0, b};
                o.result   = wide[7:0];
                o.carry    = wide[8];
                o.overflow = (a[7] != b[7]) && (o.result[7] != a[7]);
            end
            OP_AND: o.result = a & b;
            OP_OR:  o.result = a | b;
            OP_XOR: o.result = a ^ b;
            OP_NOT: o.result = ~a;
            OP_SHL: begin
                o.result = {a[6:0], 1'b0};
                o.carry  = a[7];
            end
            OP_SHR: begin
                o.result = {a[7], a[7:1]};
                o.carry  = a[0];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign alu = alu_eval(a_q, b_q, op_q);

    always_comb begin
        // NOTE: every signal written here gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            S_A: begin
                result_d = bus.Sw;
                if (press) begin
                    a_d     = bus.Sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                result_d = bus.Sw;
                if (press) begin
                    b_d     = bus.Sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                result_d = {5'b0, bus.Sw[2:0]};
                if (press) begin
                    op_d    = op_t'(bus.Sw[2:0]);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // single cycle, press not examined
                result_d = alu.result;
                carry_d  = alu.carry;
                ovf_d    = alu.overflow;
                done_d   = 1'b1;
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // NOTE: the operand registers are reset along with the control state on
    // purpose: a reset in the middle of an entry must not leave a stale A or
    // B behind for the next calculation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.Result   = result_q;
    assign bus.Stage    = state_q;
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;
    assign bus.Done     = done_q;
    assign bus.InRange  = in_display_range(result_q);

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer -- self-checking bench for ula_sequencer. Inputs are
// driven on the falling edge, outputs are sampled on the falling edge.
module tb_ula_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    ula_sequencer_if bus ();

    ula_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU from the arithmetic definitions (plain integers).
    task automatic ref_alu(input int a, input int b, input int op,
                           output int r, output int c, output int v);
        int sa, sb, s, sv;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0; v = 0; r = 0;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0;
                     sv = sa + sb; v = (sv > 127 || sv < -128) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
                     sv = sa - sb; v = (sv > 127 || sv < -128) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            default: begin r = ((sa - (a % 2)) / 2 + 256) % 256; c = a % 2; end
        endcase
    endtask

    function automatic logic ref_in_range(input int r);
        int sr;
        sr = (r >= 128) ? r - 256 : r;
        return (sr >= -9 && sr <= 89);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.Key = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One press: Key high for three edges, then low with switches wandering.
    task automatic press_key(input logic [7:0] sw);
        @(negedge clk);
        bus.Sw  = sw;
        bus.Key = 1'b1;
        repeat (3) @(negedge clk);
        bus.Key = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.Sw = 8'($urandom);
        end
    endtask

    // Full A/B/Op entry; counts Done pulses over the following cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, output int done_cnt);
        press_key(a);
        press_key(b);
        @(negedge clk);
        bus.Sw  = {5'b0, op};
        bus.Key = 1'b1;
        repeat (3) @(negedge clk);
        bus.Key  = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            bus.Sw = 8'($urandom);
            if (bus.Done === 1'b1) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.Key = 1'b0; bus.Sw = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (bus.Result !== 8'h00) begin tests_failed++; $display("FAIL reset_result: got %h want 00", bus.Result); end
        tests_run++; if (bus.Stage !== 3'd0) begin tests_failed++; $display("FAIL reset_stage: got %0d want 0", bus.Stage); end
        tests_run++; if (bus.Carry !== 1'b0) begin tests_failed++; $display("FAIL reset_carry: got %b want 0", bus.Carry); end
        tests_run++; if (bus.Overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", bus.Overflow); end
        tests_run++; if (bus.Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        tests_run++; if (bus.InRange !== 1'b1) begin tests_failed++; $display("FAIL reset_inrange: got %b want 1", bus.InRange); end
        rst = 1'b0;
    endtask

    task automatic test_echo();
        logic [7:0] v;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            @(negedge clk); bus.Sw = v;
            @(negedge clk);
            tests_run++; if (bus.Result !== v) begin tests_failed++; $display("FAIL echo_a: got %h want %h", bus.Result, v); end
        end
        press_key(8'h11);
        v = 8'($urandom);
        @(negedge clk); bus.Sw = v;
        @(negedge clk);
        tests_run++; if (bus.Result !== v) begin tests_failed++; $display("FAIL echo_b: got %h want %h", bus.Result, v); end
        press_key(8'h22);
        v = 8'($urandom) | 8'hF8;
        @(negedge clk); bus.Sw = v;
        @(negedge clk);
        tests_run++; if (bus.Result !== {5'b0, v[2:0]}) begin tests_failed++; $display("FAIL echo_op: got %h want %h", bus.Result, {5'b0, v[2:0]}); end
    endtask

    task automatic test_directed();
        int dc;
        apply_reset();
        run_op(8'd25, 8'd17, 3'b000, dc);
        tests_run++; if (bus.Result !== 8'h2A) begin tests_failed++; $display("FAIL add42_result: got %h want 2a", bus.Result); end
        tests_run++; if ({bus.Carry, bus.Overflow, bus.InRange} !== 3'b001) begin tests_failed++; $display("FAIL add42_flags: got c%b v%b r%b want c0 v0 r1", bus.Carry, bus.Overflow, bus.InRange); end
        tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL add42_done: got %0d pulses want 1", dc); end
        tests_run++; if (bus.Stage !== 3'd4) begin tests_failed++; $display("FAIL add42_stage: got %0d want 4", bus.Stage); end
        press_key(8'h00);
        run_op(8'd3, 8'd8, 3'b001, dc);
        tests_run++; if (bus.Result !== 8'hFB) begin tests_failed++; $display("FAIL sub_result: got %h want fb", bus.Result); end
        tests_run++; if ({bus.Carry, bus.Overflow, bus.InRange} !== 3'b101) begin tests_failed++; $display("FAIL sub_flags: got c%b v%b r%b want c1 v0 r1", bus.Carry, bus.Overflow, bus.InRange); end
        press_key(8'h00);
        run_op(8'd100, 8'd100, 3'b000, dc);
        tests_run++; if (bus.Result !== 8'hC8) begin tests_failed++; $display("FAIL addovf_result: got %h want c8", bus.Result); end
        tests_run++; if ({bus.Carry, bus.Overflow, bus.InRange} !== 3'b010) begin tests_failed++; $display("FAIL addovf_flags: got c%b v%b r%b want c0 v1 r0", bus.Carry, bus.Overflow, bus.InRange); end
        press_key(8'h00);
        tests_run++; if ({bus.Carry, bus.Overflow} !== 2'b00) begin tests_failed++; $display("FAIL show_exit_clear: got c%b v%b want c0 v0", bus.Carry, bus.Overflow); end
        run_op(8'h81, 8'h00, 3'b111, dc);
        tests_run++; if (bus.Result !== 8'hC0 || bus.Carry !== 1'b1) begin tests_failed++; $display("FAIL asr: got %h c%b want c0 c1", bus.Result, bus.Carry); end
        press_key(8'h00);
    endtask

    task automatic test_random();
        int a, b, op, r, c, v, dc;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            op = (i < 8) ? i : int'($urandom_range(0, 7));
            ref_alu(a, b, op, r, c, v);
            run_op(8'(a), 8'(b), 3'(op), dc);
            tests_run++;
            if (bus.Result !== 8'(r) || bus.Carry !== 1'(c) || bus.Overflow !== 1'(v) ||
                bus.InRange !== ref_in_range(r) || dc !== 1 || bus.Stage !== 3'd4) begin
                tests_failed++;
                $display("FAIL rand_op a=%h b=%h op=%0d: got r=%h c%b v%b ir%b done=%0d st=%0d want r=%h c%0d v%0d ir%b done=1 st=4",
                         a, b, op, bus.Result, bus.Carry, bus.Overflow, bus.InRange, dc, bus.Stage,
                         8'(r), c, v, ref_in_range(r));
            end
            press_key(8'($urandom));
            tests_run++;
            if (bus.Stage !== 3'd0 || bus.Carry !== 1'b0 || bus.Overflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_return: got st=%0d c%b v%b want st=0 c0 v0", bus.Stage, bus.Carry, bus.Overflow);
            end
        end
    endtask

    task automatic test_key_hold();
        int trans, first;
        logic [2:0] prev;
        apply_reset();
        @(negedge clk);
        bus.Key = 1'b1;
        prev  = bus.Stage;
        trans = 0;
        first = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.Stage !== prev) begin
                trans++;
                if (first < 0) first = i;
            end
            prev = bus.Stage;
        end
        bus.Key = 1'b0;
        tests_run++; if (trans !== 1 || first !== 3 || prev !== 3'd1) begin tests_failed++; $display("FAIL key_hold: got %0d transitions first at edge %0d stage %0d want 1 at 3 stage 1", trans, first, prev); end
    endtask

    task automatic test_reset_priority();
        logic [2:0] seen [3];
        apply_reset();
        @(negedge clk);
        bus.Key = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;                      // press is due on this very edge
        @(negedge clk);
        tests_run++; if (bus.Stage !== 3'd0) begin tests_failed++; $display("FAIL rst_priority: got stage %0d want 0", bus.Stage); end
        rst = 1'b0;                      // Key still high across release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = bus.Stage;
        end
        bus.Key = 1'b0;
        tests_run++; if (seen[0] !== 3'd0 || seen[1] !== 3'd0 || seen[2] !== 3'd1) begin tests_failed++; $display("FAIL key_across_release: got stages %0d %0d %0d want 0 0 1", seen[0], seen[1], seen[2]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, r, c, v, b;
        apply_reset();
        press_key(8'h55);
        press_key(8'h33);
        @(negedge clk);
        bus.Sw = 8'h06;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (bus.Stage !== 3'd0 || bus.Result !== 8'h00) begin tests_failed++; $display("FAIL rst_mid: got stage %0d result %h want 0 00", bus.Stage, bus.Result); end
        b = int'($urandom_range(1, 255));
        ref_alu(0, b, 0, r, c, v);
        run_op(8'h00, 8'(b), 3'b000, dc);
        tests_run++; if (bus.Result !== 8'(r)) begin tests_failed++; $display("FAIL rst_mid_discard: got %h want %h", bus.Result, 8'(r)); end
    endtask

    initial begin
        bus.Sw  = 8'h00;
        bus.Key = 1'b0;
        rst     = 1'b1;
        test_reset();
        test_echo();
        test_directed();
        test_random();
        test_key_hold();
        test_reset_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ula_sequencer.md
ULA_SEQUENCER -- requirements
Module: ula_sequencer

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 Sw  in  8  operand/opcode switches; sampled, not synchronized.
REQ-005 Key  in  1  raw active-high push button, asynchronous to clk.
REQ-006 Result  out  8  registered value for the downstream 2-digit 7-segment decoder.
REQ-007 Stage  out  3  current state encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
REQ-008 Carry, Overflow  out  1 each  registered ALU flags.
REQ-009 InRange  out  1  high when signed Result lies in -9..89, the range the decoder can display.
REQ-010 Done  out  1  one-cycle pulse when a new result is registered.

Function
REQ-011 Key SHALL pass through three flops k1->k2->k3; press = k2 & ~k3; a press is acted on at the third rising edge after Key rises.
REQ-012 A Key held high for any duration SHALL yield exactly one press.
REQ-013 S_A: Result echoes Sw (one-cycle latency); on press, A<=Sw, go to S_B.
REQ-014 S_B: Result echoes Sw; on press, B<=Sw, go to S_OP.
REQ-015 S_OP: Result echoes {5'b0,Sw[2:0]}; on press, Op<=Sw[2:0], go to S_EXEC.
REQ-016 S_EXEC SHALL last exactly one cycle: register Result, Carry, Overflow, pulse Done, go to S_SHOW; presses in S_EXEC are ignored.
REQ-017 S_SHOW: hold Result and flags; on press, go to S_A and clear Carry and Overflow.
REQ-018 Op codes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A<<1, 111 A>>>1 (arithmetic).
REQ-019 All arithmetic SHALL be 8-bit, wrapping modulo 256; operands are two's complement.
REQ-020 Carry: add carry-out; sub borrow (A<B unsigned); shl = A[7]; shr = A[0]; logic ops = 0.
REQ-021 Overflow: signed overflow for add/sub only, else 0.
REQ-022 InRange SHALL be combinational from Result in every state.
REQ-023 Sw changes without a press SHALL affect only the echoed Result, never A, B or Op.

Reset
REQ-024 Reset SHALL set state S_A; A, B, Op, Result = 0; Carry, Overflow, Done = 0; k1, k2, k3 = 0.
REQ-025 Reset SHALL take priority over any press at the same edge.
REQ-026 Reset mid-operation (any state) SHALL discard captured operands.
REQ-027 If Key is high across reset release, one press SHALL be acted on at the third edge after release.

Structure
REQ-028 State encodings and op-code constants SHALL live in the shared package ula_pkg.
REQ-029 The synchronizer and edge detector SHALL be a sub-module, key_edge (ports clk, rst, Key, press).
REQ-030 The ALU SHALL be a combinational function or block inside ula_sequencer; the 7-segment decoding stays downstream.

Verification
REQ-031 Hold rst 2 cycles -> Result=0x00, Stage=0, Carry=0, Overflow=0, Done=0, InRange=1.
REQ-032 A=25, B=17, Op=000 -> Result=0x2A (42), Carry=0, Overflow=0, InRange=1, Done high for exactly 1 cycle, Stage=4.
REQ-033 A=3, B=8, Op=001 -> Result=0xFB (-5), Carry=1, Overflow=0, InRange=1.
REQ-034 A=100, B=100, Op=000 -> Result=0xC8, Overflow=1, Carry=0, InRange=0; A=0x81, Op=111 -> Result=0xC0, Carry=1.
REQ-035 Key held high 50 cycles in S_A -> exactly one transition, to S_B, at the third edge after Key rises.
REQ-036 Assert rst while in S_OP -> at the next edge Stage=0 and Result=0; a following B-only entry computes with A=0.
